// File: rtl/mat_morph_seq_if.sv
// Address-calculator, source-read and destination-write bus of the morphology sequencer.
interface mat_morph_seq_if;
    logic [14:0] refAddr;
    logic [4:0]  regAddr;
    logic [14:0] srmAddr;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic        rd_data;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic        wr_data;

    modport master (
        output refAddr, regAddr, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  srmAddr, rd_data
    );

    modport slave (
        input  refAddr, regAddr, rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output srmAddr, rd_data
    );
endinterface

// File: rtl/mat_morph_seq.sv
// Raster-scan sequencer for diamond-neighbourhood binary erosion/dilation:
// 27 tap reads per pixel, AND/OR fold, one result write per pixel.
module mat_morph_seq #(
    parameter int unsigned IMG_W      = 180,
    parameter int unsigned IMG_H      = 120,
    parameter bit          BORDER_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mode,
    output logic busy,
    output logic done,
    mat_morph_seq_if.master bus
);
    localparam int unsigned XW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned AW       = 15;
    localparam int unsigned TW       = 5;
    localparam int unsigned LAST_TAP = 26;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [TW-1:0] tap_q, tap_d;
    logic [AW-1:0] ref_q, ref_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          mode_q, mode_d;
    logic          acc_q, acc_d;
    logic          pend_q, pend_d;
    logic          vld_q, vld_d;
    logic          rd_en_q, rd_en_d;
    logic          wr_en_q, wr_en_d;
    logic          wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fold_bit;
    logic          last_pix;

    // In-frame test from the pixel counters, so linear-address wrap never aliases a neighbour.
    function automatic logic tap_in_frame(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                          input logic [TW-1:0] tap);
        int t, dx, dy, px, py;
        t  = int'(tap);
        dx = 0;
        dy = 0;
        if (t == 1) begin
            dy = -3;
        end else if (t >= 2 && t <= 4) begin
            dx = t - 3;
            dy = -2;
        end else if (t >= 5 && t <= 9) begin
            dx = t - 7;
            dy = -1;
        end else if (t >= 10 && t <= 13) begin
            dx = t - 14;
        end else if (t >= 14 && t <= 17) begin
            dx = t - 13;
        end else if (t >= 18 && t <= 22) begin
            dx = t - 20;
            dy = 1;
        end else if (t >= 23 && t <= 25) begin
            dx = t - 24;
            dy = 2;
        end else if (t == 26) begin
            dy = 3;
        end
        px = int'(x) + dx;
        py = int'(y) + dy;
        return (px >= 0) && (px < int'(IMG_W)) && (py >= 0) && (py < int'(IMG_H));
    endfunction

    assign last_pix = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        tap_d     = tap_q;
        ref_d     = ref_q;
        wr_addr_d = wr_addr_q;
        mode_d    = mode_q;
        acc_d     = acc_q;
        pend_d    = 1'b0;
        vld_d     = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 1'b0;
        wr_data_d = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Read data returns one cycle after its strobe; out-of-frame slots fold the border value.
        fold_bit = vld_q ? bus.rd_data : BORDER_VAL;
        if (pend_q) begin
            acc_d = mode_q ? (acc_q | fold_bit) : (acc_q & fold_bit);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                    mode_d  = mode;
                    x_d     = '0;
                    y_d     = '0;
                    tap_d   = '0;
                    ref_d   = '0;
                    busy_d  = 1'b1;
                    rd_en_d = 1'b1;
                end
            end
            ST_FETCH: begin
                pend_d = 1'b1;
                vld_d  = rd_en_q;
                if (tap_q == '0) begin
                    acc_d = ~mode_q;
                end
                if (tap_q == TW'(LAST_TAP)) begin
                    state_d = ST_WAIT;
                end else begin
                    tap_d   = tap_q + TW'(1);
                    rd_en_d = tap_in_frame(x_q, y_q, tap_d);
                end
            end
            ST_WAIT: begin
                state_d   = ST_WRITE;
                wr_en_d   = 1'b1;
                wr_addr_d = ref_q;
                wr_data_d = acc_d;
            end
            ST_WRITE: begin
                if (last_pix) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    tap_d   = '0;
                    ref_d   = '0;
                end else begin
                    state_d = ST_FETCH;
                    tap_d   = '0;
                    rd_en_d = 1'b1;
                    ref_d   = ref_q + AW'(1);
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + YW'(1);
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            tap_q     <= '0;
            ref_q     <= '0;
            wr_addr_q <= '0;
            mode_q    <= 1'b0;
            acc_q     <= 1'b0;
            pend_q    <= 1'b0;
            vld_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            tap_q     <= tap_d;
            ref_q     <= ref_d;
            wr_addr_q <= wr_addr_d;
            mode_q    <= mode_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            vld_q     <= vld_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.refAddr = ref_q;
    assign bus.regAddr = tap_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = bus.srmAddr;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_mat_morph_seq.sv
// Scoreboard bench for mat_morph_seq on a reduced 12x8 frame, one instance per border value.
module tb_mat_morph_seq;
    localparam int W       = 12;
    localparam int H       = 8;
    localparam int N       = W * H;
    localparam int PIX_CYC = 29;

    typedef struct packed {
        logic [14:0] a;
        logic        d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [1:0]  busy_w;
    logic [1:0]  done_w;
    logic        rd_en_w   [2];
    logic        wr_en_w   [2];
    logic        wr_data_w [2];
    logic [14:0] rd_addr_w [2];
    logic [14:0] wr_addr_w [2];
    logic [14:0] ref_w     [2];
    logic [4:0]  reg_w     [2];
    logic [7:0]  act_w     [2];

    bit  src [N];
    int  DX [27] = '{0, 0, -1, 0, 1, -2, -1, 0, 1, 2, -4, -3, -2, -1, 1, 2, 3, 4,
                     -2, -1, 0, 1, 2, -1, 0, 1, 0};
    int  DY [27] = '{0, -3, -2, -2, -2, -1, -1, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 1, 1, 1, 1, 2, 2, 2, 3};
    wr_t exp0 [$];
    wr_t exp1 [$];
    int  n_cmp    = 0;
    int  n_err    = 0;
    int  done_cnt = 0;
    int  cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Neighbouring address calculator: linear offset with the same row stride as the frame.
    function automatic logic [14:0] calc_addr(input logic [14:0] r, input logic [4:0] t);
        int ti;
        ti = int'(t);
        if (ti > 26) return r;
        return 15'(int'(r) + DY[ti] * W + DX[ti]);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mat_morph_seq_if bus ();

        mat_morph_seq #(.IMG_W(W), .IMG_H(H), .BORDER_VAL(g == 1)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .mode  (mode),
            .busy  (busy_w[g]),
            .done  (done_w[g]),
            .bus   (bus.master)
        );

        assign bus.srmAddr = calc_addr(bus.refAddr, bus.regAddr);

        // Source SRAM: one-cycle latency; junk when not strobed so unqualified folds show up.
        always @(posedge clk)
            bus.rd_data <= (bus.rd_en && int'(bus.rd_addr) < N) ? src[int'(bus.rd_addr)]
                                                                : 1'($urandom);

        assign rd_en_w[g]   = bus.rd_en;
        assign wr_en_w[g]   = bus.wr_en;
        assign wr_data_w[g] = bus.wr_data;
        assign rd_addr_w[g] = bus.rd_addr;
        assign wr_addr_w[g] = bus.wr_addr;
        assign ref_w[g]     = bus.refAddr;
        assign reg_w[g]     = bus.regAddr;
        assign act_w[g]     = {busy_w[g], done_w[g], bus.rd_en, bus.wr_en, bus.wr_data,
                               |bus.refAddr, |bus.regAddr, |bus.wr_addr};
    end

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: every pixel folds its 27 diamond neighbours, border value where off-frame.
    task automatic build_exp(input bit m);
        for (int bd = 0; bd < 2; bd++) begin
            for (int y = 0; y < H; y++) begin
                for (int x = 0; x < W; x++) begin
                    bit  acc;
                    bit  v;
                    wr_t e;
                    acc = !m;
                    for (int k = 0; k < 27; k++) begin
                        int px, py;
                        px = x + DX[k];
                        py = y + DY[k];
                        v  = (px >= 0 && px < W && py >= 0 && py < H) ? src[py * W + px] : bit'(bd);
                        acc = m ? (acc | v) : (acc & v);
                    end
                    e.a = 15'(y * W + x);
                    e.d = acc;
                    if (bd == 0) exp0.push_back(e);
                    else         exp1.push_back(e);
                end
            end
        end
    endtask

    task automatic mon_write(input int g);
        wr_t e;
        bit  have;
        n_cmp++;
        if (rd_en_w[g]) begin
            n_err++;
            $display("FAIL rd_wr_overlap inst%0d: rd_en=1 with wr_en=1, required rd_en=0", g);
        end
        have = (g == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
        n_cmp++;
        if (!have) begin
            n_err++;
            $display("FAIL unexpected_write inst%0d: addr %0d data %0d, required no write",
                     g, wr_addr_w[g], wr_data_w[g]);
        end else begin
            e = (g == 0) ? exp0.pop_front() : exp1.pop_front();
            if (wr_addr_w[g] !== e.a || wr_data_w[g] !== e.d) begin
                n_err++;
                $display("FAIL write inst%0d: addr %0d data %0d, required addr %0d data %0d",
                         g, wr_addr_w[g], wr_data_w[g], e.a, e.d);
            end
        end
    endtask

    task automatic mon_read(input int g);
        int r, t, px, py;
        bit ok;
        r  = int'(ref_w[g]);
        t  = int'(reg_w[g]);
        ok = 1'b0;
        px = -1;
        py = -1;
        if (t <= 26) begin
            px = r % W + DX[t];
            py = r / W + DY[t];
            ok = px >= 0 && px < W && py >= 0 && py < H &&
                 int'(rd_addr_w[g]) == py * W + px && int'(rd_addr_w[g]) < N;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL read inst%0d ref %0d tap %0d: rd_addr %0d, required in-frame (%0d,%0d)",
                     g, r, t, rd_addr_w[g], px, py);
        end
    endtask

    // Monitor: checks every write against the scoreboard and every read for in-frame legality.
    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (done_w[g]) done_cnt++;
                if (wr_en_w[g]) mon_write(g);
                if (rd_en_w[g]) mon_read(g);
            end
        end
    end

    task automatic run_frame(input bit m, input bit extra, input bit do_rst);
        int t0, d0;
        bit hit;
        build_exp(m);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy_w), 3);
        if (extra) begin
            repeat (100) @(negedge clk);
            start = 1'b1;
            mode  = !m;
            @(negedge clk);
            start = 1'b0;
        end
        if (do_rst) begin
            hit = 1'b0;
            for (int k = 0; k < N * PIX_CYC && !hit; k++) begin
                @(negedge clk);
                hit = (ref_w[0] == 15'd50) && (reg_w[0] == 5'd13);
            end
            chk("reset_point_reached", int'(hit), 1);
            exp0.delete();
            exp1.delete();
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("abort_outs_inst0", int'(act_w[0]), 0);
            chk("abort_outs_inst1", int'(act_w[1]), 0);
            repeat (2 * PIX_CYC) @(negedge clk);
            chk("abort_stays_idle", int'(busy_w), 0);
            chk("abort_no_done", done_cnt - d0, 0);
            return;
        end
        hit = 1'b0;
        for (int k = 0; k < N * PIX_CYC + 200 && !hit; k++) begin
            @(negedge clk);
            hit = (done_w != 2'b00);
        end
        chk("done_seen", int'(hit), 1);
        if (hit) begin
            chk("done_latency", cyc - t0, N * PIX_CYC);
            chk("done_both", int'(done_w), 3);
        end
        @(negedge clk);
        chk("done_one_cycle", int'(done_w), 0);
        chk("busy_after_done", int'(busy_w), 0);
        repeat (20) @(negedge clk);
        chk("pending_writes", exp0.size() + exp1.size(), 0);
        chk("done_count", done_cnt - d0, 2);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs_inst0", int'(act_w[0]), 0);
        chk("reset_outs_inst1", int'(act_w[1]), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // All-ones erosion: interior ones only with border 0, all ones with border 1.
        for (int i = 0; i < N; i++) src[i] = 1'b1;
        run_frame(1'b0, 1'b0, 1'b0);

        // Single set pixel dilated into its diamond.
        for (int i = 0; i < N; i++) src[i] = 1'b0;
        src[4 * W + 6] = 1'b1;
        run_frame(1'b1, 1'b0, 1'b0);

        // Dense random erosion with a second start and mode flip mid-frame.
        for (int i = 0; i < N; i++) src[i] = ($urandom % 10) != 0;
        run_frame(1'b0, 1'b1, 1'b0);

        // Reset in the middle of pixel 50, then a clean frame from pixel 0.
        for (int i = 0; i < N; i++) src[i] = $urandom % 2;
        run_frame(1'($urandom % 2), 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, 1'b0);

        // Sparse random dilation with a second start and mode flip mid-frame.
        for (int i = 0; i < N; i++) src[i] = ($urandom % 12) == 0;
        run_frame(1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
